nios2_mul_unit: RTL and testbench

//  Parametrised, fully pipelined integer multiplier for the Nios II M-stage datapath.

---
 rtl/nios2_mul_pkg.sv | 23 ++
 rtl/nios2_mul_unit_if.sv | 27 ++
 rtl/nios2_mul_tile16.sv | 25 ++
 rtl/nios2_mul_unit.sv | 128 ++++++++++++
 tb/tb_nios2_mul_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the Nios II M-stage multiplier.
//   MUL_OP_*        2-bit op encodings carried on in_op
//   TILE_W          width of one partial-product tile
//   is_signed_a/b   operand signedness for a given op
package nios2_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;  // low word
  localparam logic [1:0] MUL_OP_MULXUU = 2'b01;  // high word, unsigned x unsigned
  localparam logic [1:0] MUL_OP_MULXSU = 2'b10;  // high word, signed x unsigned
  localparam logic [1:0] MUL_OP_MULXSS = 2'b11;  // high word, signed x signed

  localparam int TILE_W = 16;

  // MUL is treated as unsigned: its low word does not depend on signedness.
  function automatic logic is_signed_a(input logic [1:0] op);
    return (op != MUL_OP_MUL) && (op != MUL_OP_MULXUU);
  endfunction

  function automatic logic is_signed_b(input logic [1:0] op);
    return op == MUL_OP_MULXSS;
  endfunction

endpackage

// File: rtl/nios2_mul_unit_if.sv
// Issue/result bundle between decode/issue, the multiplier and the W-stage mux.
//   in_valid, in_op, in_src1, in_src2   issue side
//   stall, flush                         pipeline control
//   out_valid, out_result                result side
// master: issue logic (drives operands and control); slave: the multiplier.
interface nios2_mul_unit_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;

  modport master (
    output in_valid, in_op, in_src1, in_src2, stall, flush,
    input  out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, stall, flush,
    output out_valid, out_result
  );
endinterface

// File: rtl/nios2_mul_tile16.sv
// Registered 16x16 unsigned multiply tile.
//   clk, reset_n   clock, asynchronous active-low clear
//   en             capture a*b when high, hold otherwise
//   a, b           16-bit unsigned operands
//   p              registered 32-bit product
module nios2_mul_tile16
  import nios2_mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [TILE_W-1:0]     a,
  input  logic [TILE_W-1:0]     b,
  output logic [2*TILE_W-1:0]   p
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
    end else if (en) begin
      p <= (2*TILE_W)'(a) * (2*TILE_W)'(b);
    end
  end

endmodule

// File: rtl/nios2_mul_unit.sv
// Fully pipelined Nios II multiplier (MUL / MULXUU / MULXSU / MULXSS).
//   clk, reset_n   clock, asynchronous active-low reset
//   bus            nios2_mul_unit_if.slave: issue, stall/flush, result
// Stage 1 registers the unsigned 16x16 tiles plus op and operand sign info.
// Stage 2 sums the tiles, applies signed corrections and selects the word.
// Stages 3..LATENCY are a plain output pipe.
module nios2_mul_unit
  import nios2_mul_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  nios2_mul_unit_if.slave bus
);

  localparam int NT   = DATA_W / TILE_W;
  localparam int PW   = 2 * DATA_W;
  localparam int PP_W = 2 * TILE_W;

  if ((DATA_W % TILE_W) != 0 || DATA_W < 16 || DATA_W > 64) begin : g_bad_data_w
    $error("nios2_mul_unit: DATA_W must be a multiple of 16 within 16..64");
  end
  if (LATENCY < 2 || LATENCY > 4) begin : g_bad_latency
    $error("nios2_mul_unit: LATENCY must be within 2..4");
  end

  // Data registers move only when not stalled; flush touches valids only.
  logic advance;
  assign advance = !bus.stall;

  // ---------------- stage 1 ----------------
  logic              s1_valid;
  logic [1:0]        s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s1_a_neg;
  logic              s1_b_neg;
  logic [PP_W-1:0]   tile_p [NT*NT];

  for (genvar i = 0; i < NT; i++) begin : g_row
    for (genvar j = 0; j < NT; j++) begin : g_col
      nios2_mul_tile16 u_tile (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (advance),
        .a       (bus.in_src1[i*TILE_W +: TILE_W]),
        .b       (bus.in_src2[j*TILE_W +: TILE_W]),
        .p       (tile_p[i*NT+j])
      );
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_op    <= MUL_OP_MUL;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_a_neg <= 1'b0;
      s1_b_neg <= 1'b0;
    end else if (advance) begin
      s1_op    <= bus.in_op;
      s1_a     <= bus.in_src1;
      s1_b     <= bus.in_src2;
      s1_a_neg <= is_signed_a(bus.in_op) && bus.in_src1[DATA_W-1];
      s1_b_neg <= is_signed_b(bus.in_op) && bus.in_src2[DATA_W-1];
    end
  end

  // ---------------- stage 2: sum + select ----------------
  // A signed operand X equals unsigned(X) - 2^DATA_W when negative, so the
  // signed product is the unsigned one minus (other << DATA_W) per negative
  // operand; the cross term 2^(2*DATA_W) vanishes modulo the product width.
  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] sel_word;

  always_comb begin
    prod = '0;
    for (int i = 0; i < NT; i++) begin
      for (int j = 0; j < NT; j++) begin
        prod = prod + (PW'(tile_p[i*NT+j]) << (TILE_W * (i + j)));
      end
    end
    if (s1_a_neg) prod = prod - {s1_b, {DATA_W{1'b0}}};
    if (s1_b_neg) prod = prod - {s1_a, {DATA_W{1'b0}}};
    sel_word = (s1_op == MUL_OP_MUL) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
  end

  // ---------------- stages 2..LATENCY ----------------
  logic [DATA_W-1:0] d_pipe [2:LATENCY];
  logic [LATENCY:2]  v_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 2; k <= LATENCY; k++) begin
        d_pipe[k] <= '0;
      end
    end else if (advance) begin
      d_pipe[2] <= sel_word;
      for (int k = 3; k <= LATENCY; k++) begin
        d_pipe[k] <= d_pipe[k-1];
      end
    end
  end

  // Valid shift register: s1_valid plus v_pipe, LATENCY bits in total.
  // Flush wins over stall and also drops an issue presented in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      v_pipe   <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      v_pipe   <= '0;
    end else if (advance) begin
      s1_valid  <= bus.in_valid;
      v_pipe[2] <= s1_valid;
      for (int k = 3; k <= LATENCY; k++) begin
        v_pipe[k] <= v_pipe[k-1];
      end
    end
  end

  assign bus.out_valid  = v_pipe[LATENCY];
  assign bus.out_result = d_pipe[LATENCY];

endmodule

// File: tb/tb_nios2_mul_unit.sv
// Scoreboard bench for nios2_mul_unit: a 32-bit/latency-2 instance for the
// directed vectors and a 64-bit/latency-4 instance for flush and a random run.
module tb_nios2_mul_unit;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_UU  = 2'b01;
  localparam logic [1:0] OP_SU  = 2'b10;
  localparam logic [1:0] OP_SS  = 2'b11;

  typedef struct {
    logic [63:0] res;
    int          cyc;   // expected presentation cycle, -1 = not checked
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nios2_mul_unit_if #(.DATA_W(32)) bus32 ();
  nios2_mul_unit_if #(.DATA_W(64)) bus64 ();

  nios2_mul_unit #(.DATA_W(32), .LATENCY(2)) u_dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus32)
  );

  nios2_mul_unit #(.DATA_W(64), .LATENCY(4)) u_dut64 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus64)
  );

  // Hand-computed directed vectors, issued back to back.
  vec_t vecs [14] = '{
    '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
    '{OP_UU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{OP_SU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{OP_SS,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
    '{OP_SS,  32'h80000000, 32'h80000000, 32'h40000000},
    '{OP_UU,  32'h80000000, 32'h80000000, 32'h40000000},
    '{OP_MUL, 32'h80000000, 32'h80000000, 32'h00000000},
    '{OP_MUL, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080},
    '{OP_UU,  32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E},
    '{OP_SU,  32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E},
    '{OP_SS,  32'h12345678, 32'h9ABCDEF0, 32'hF8CC93D6},
    '{OP_SU,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF},
    '{OP_SU,  32'h00000002, 32'h80000000, 32'h00000001},
    '{OP_SS,  32'h00000002, 32'h80000000, 32'hFFFFFFFF}
  };

  // Independent 128-bit reference for the 64-bit instance.
  function automatic logic [63:0] golden64(input logic [1:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = {64'b0, a};
    eb = {64'b0, b};
    if ((op == OP_SU || op == OP_SS) && a[63]) ea[127:64] = '1;
    if (op == OP_SS && b[63]) eb[127:64] = '1;
    p = ea * eb;
    return (op == OP_MUL) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0:       return 64'h8000000000000000;
      1:       return 64'hFFFFFFFFFFFFFFFF;
      2:       return 64'h7FFFFFFFFFFFFFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus on one instance; accepted issues go to its queue.
  task automatic drive(input bit wide, input logic v, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic st, input logic fl,
                       input logic [63:0] exp_res, input int extra);
    int ec;
    @(posedge clk);
    #2;
    if (!wide) begin
      bus32.in_valid = v;  bus32.in_op = op;
      bus32.in_src1  = a[31:0];  bus32.in_src2 = b[31:0];
      bus32.stall    = st; bus32.flush = fl;
      ec = (extra < 0) ? -1 : cyc + 2 + extra;
      if (v && !st && !fl) q32.push_back('{exp_res, ec});
    end else begin
      bus64.in_valid = v;  bus64.in_op = op;
      bus64.in_src1  = a;  bus64.in_src2 = b;
      bus64.stall    = st; bus64.flush = fl;
      ec = (extra < 0) ? -1 : cyc + 4 + extra;
      if (v && !st && !fl) q64.push_back('{exp_res, ec});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      bus32.in_valid = 1'b0; bus32.stall = 1'b0; bus32.flush = 1'b0;
      bus64.in_valid = 1'b0; bus64.stall = 1'b0; bus64.flush = 1'b0;
    end
  endtask

  // Monitors: a result counts when presented and not held by stall or squashed by flush.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus32.out_valid && !bus32.stall && !bus32.flush) begin
        n_tests++;
        if (q32.size() == 0) begin
          n_fail++;
          $display("FAIL mon32_unexpected: out_valid=1 result=%h at cycle %0d, expected no output",
                   bus32.out_result, cyc);
        end else begin
          e = q32.pop_front();
          if (64'(bus32.out_result) !== e.res || (e.cyc >= 0 && cyc != e.cyc)) begin
            n_fail++;
            $display("FAIL mon32_result: got %h at cycle %0d, expected %h at cycle %0d",
                     bus32.out_result, cyc, e.res[31:0], e.cyc);
          end
        end
      end
      if (bus32.flush) q32.delete();
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus64.out_valid && !bus64.stall && !bus64.flush) begin
        n_tests++;
        if (q64.size() == 0) begin
          n_fail++;
          $display("FAIL mon64_unexpected: out_valid=1 result=%h at cycle %0d, expected no output",
                   bus64.out_result, cyc);
        end else begin
          e = q64.pop_front();
          if (bus64.out_result !== e.res || (e.cyc >= 0 && cyc != e.cyc)) begin
            n_fail++;
            $display("FAIL mon64_result: got %h at cycle %0d, expected %h at cycle %0d",
                     bus64.out_result, cyc, e.res, e.cyc);
          end
        end
      end
      if (bus64.flush) q64.delete();
    end
  end

  initial begin
    logic        v, st, fl;
    logic [1:0]  op;
    logic [63:0] a, b;
    int          accepted;

    bus32.in_valid = 1'b0; bus32.in_op = OP_MUL; bus32.in_src1 = '0; bus32.in_src2 = '0;
    bus32.stall = 1'b0; bus32.flush = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_op = OP_MUL; bus64.in_src1 = '0; bus64.in_src2 = '0;
    bus64.stall = 1'b0; bus64.flush = 1'b0;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("rst_valid32",  64'(bus32.out_valid),  64'd0);
    check("rst_result32", 64'(bus32.out_result), 64'd0);
    check("rst_valid64",  64'(bus64.out_valid),  64'd0);
    check("rst_result64", bus64.out_result,      64'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    idle(2);

    // Directed vectors, one per cycle, all ops mixed
    foreach (vecs[i]) begin
      drive(0, 1'b1, vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), 1'b0, 1'b0, 64'(vecs[i].r), 0);
    end
    idle(6);

    // Stall at cycle 1 for 3 cycles; the issue attempted during stall must be ignored
    drive(0, 1'b1, OP_SS, 64'h12345678, 64'h9ABCDEF0, 1'b0, 1'b0, 64'hF8CC93D6, 3);
    drive(0, 1'b1, OP_MUL, 64'h00000003, 64'h00000005, 1'b1, 1'b0, 64'h0, 0);
    drive(0, 1'b1, OP_MUL, 64'h00000003, 64'h00000005, 1'b1, 1'b0, 64'h0, 0);
    drive(0, 1'b0, OP_MUL, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 0);
    idle(6);

    // Stall while the result is on the output: value and valid hold
    drive(0, 1'b1, OP_MUL, 64'hFFFFFFFE, 64'hFFFFFFFD, 1'b0, 1'b0, 64'h00000006, 2);
    drive(0, 1'b0, OP_MUL, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 0);
    drive(0, 1'b0, OP_MUL, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 0);
    @(negedge clk);
    check("hold_valid_a",  64'(bus32.out_valid),  64'd1);
    check("hold_result_a", 64'(bus32.out_result), 64'h00000006);
    drive(0, 1'b0, OP_MUL, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 0);
    @(negedge clk);
    check("hold_valid_b",  64'(bus32.out_valid),  64'd1);
    check("hold_result_b", 64'(bus32.out_result), 64'h00000006);
    idle(6);

    // Flush on the 32-bit unit: op in stage 1 squashed, issue in the flush cycle dropped
    drive(0, 1'b1, OP_UU, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE, 0);
    drive(0, 1'b1, OP_MUL, 64'h00000007, 64'h00000009, 1'b0, 1'b1, 64'h0, 0);
    drive(0, 1'b1, OP_SS, 64'h80000000, 64'h80000000, 1'b0, 1'b0, 64'h40000000, 0);
    idle(6);

    // Flush on the 64-bit unit with two ops in flight
    drive(1, 1'b1, OP_SS, 64'hFFFFFFFFFFFFFFFE, 64'h3, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 0);
    drive(1, 1'b1, OP_UU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFE, 0);
    drive(1, 1'b0, OP_MUL, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 0);
    drive(1, 1'b1, OP_UU, 64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0, 64'h4000000000000000, 0);
    drive(1, 1'b1, OP_SU, 64'hFFFFFFFFFFFFFFFE, 64'h3, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 0);
    idle(10);

    // Asynchronous reset with one result on the output and one op behind it
    drive(0, 1'b1, OP_UU, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE, 0);
    drive(0, 1'b1, OP_MUL, 64'h12345678, 64'h9ABCDEF0, 1'b0, 1'b0, 64'h242D2080, 0);
    idle(1);
    #1;
    check("pre_rst_valid",  64'(bus32.out_valid),  64'd1);
    check("pre_rst_result", 64'(bus32.out_result), 64'hFFFFFFFE);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid",  64'(bus32.out_valid),  64'd0);
    check("async_rst_result", 64'(bus32.out_result), 64'd0);
    q32.delete();
    q64.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    idle(8);

    // Random regression on the 64-bit, latency-4 unit
    accepted = 0;
    while (accepted < 10000) begin
      v  = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 49) == 0);
      op = 2'($urandom_range(0, 3));
      a  = pick64();
      b  = pick64();
      drive(1, v, op, a, b, st, fl, golden64(op, a, b), -1);
      if (v && !st && !fl) accepted++;
    end
    idle(10);

    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q64_drained", 64'(q64.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
